w_ptr_full: RTL

//  Write-side pointer and full-flag generator for the async FIFO. It is the write-domain counterpart of the read-pointer/empty logic.

---
 rtl/w_ptr_full.sv | 108 ++++++++++
 1 files changed

// File: rtl/w_ptr_full.sv
// ---------------------------------------------------------------------------
// w_ptr_full
//   Write-side pointer and full-flag generator for an asynchronous FIFO.
//   Keeps a binary write counter and its registered Gray-coded copy. It
//   compares the Gray pointer with the read pointer that has already been
//   synchronised into w_clk. From that comparison it produces the full flag,
//   the almost-full flag, a free-slot count and a sticky overflow error.
//
// Ports
//   w_clk          in   write-domain clock, rising edge
//   w_rst_n        in   synchronous active-low reset
//   w_inc          in   write request, accepted only while w_full=0
//   ff2_r_ptr      in   Gray read pointer, already 2-flop synchronised
//   w_ovf_clr      in   clears w_overflow (a simultaneous set wins)
//   w_ptr          out  registered Gray write pointer (to r-domain sync)
//   w_addr         out  RAM write address (binary counter LSBs)
//   w_full         out  registered full flag
//   w_almost_full  out  registered, free slots <= AFULL_THRESH
//   w_free         out  registered free-slot count, 0..DEPTH
//   w_overflow     out  sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module w_ptr_full #(
    parameter int ADDR_BITS    = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 w_inc,
    input  logic [ADDR_BITS:0]   ff2_r_ptr,
    input  logic                 w_ovf_clr,
    output logic [ADDR_BITS:0]   w_ptr,
    output logic [ADDR_BITS-1:0] w_addr,
    output logic                 w_full,
    output logic                 w_almost_full,
    output logic [ADDR_BITS:0]   w_free,
    output logic                 w_overflow
);

    localparam int A     = ADDR_BITS;
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [A:0] DEPTH_V = DEPTH[A:0];
    localparam logic [A:0] AFT_V   = AFULL_THRESH[A:0];

    logic [A:0] w_bin_q,  w_bin_d;
    logic [A:0] w_ptr_q,  w_ptr_d;
    logic       w_full_q, w_full_d;
    logic       w_af_q,   w_af_d;
    logic [A:0] w_free_q, w_free_d;
    logic       w_ovf_q,  w_ovf_d;

    logic       wr_en;
    logic [A:0] r_bin_s;
    logic [A:0] used;
    logic [A:0] full_cmp;

    // Gray-to-binary: each bit is the XOR of itself and all higher bits.
    always_comb begin
        r_bin_s = '0;
        r_bin_s[A] = ff2_r_ptr[A];
        for (int i = A - 1; i >= 0; i--) begin
            r_bin_s[i] = r_bin_s[i+1] ^ ff2_r_ptr[i];
        end
    end

    // Full is evaluated on the next pointer, so the flag rises on the same
    // edge that accepts the DEPTH-th outstanding write. The Gray-domain full
    // pattern is the read pointer with its two MSBs inverted.
    always_comb begin
        wr_en    = w_inc & ~w_full_q;
        w_bin_d  = w_bin_q + {{A{1'b0}}, wr_en};
        w_ptr_d  = (w_bin_d >> 1) ^ w_bin_d;
        full_cmp = {~ff2_r_ptr[A:A-1], ff2_r_ptr[A-2:0]};
        w_full_d = (w_ptr_d == full_cmp);
        used     = w_bin_d - r_bin_s;
        w_free_d = DEPTH_V - used;
        w_af_d   = (w_free_d <= AFT_V);
        // Set has priority over clear on the same edge.
        w_ovf_d  = w_ovf_q;
        if (w_ovf_clr) w_ovf_d = 1'b0;
        if (w_inc && w_full_q) w_ovf_d = 1'b1;
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            w_bin_q  <= '0;
            w_ptr_q  <= '0;
            w_full_q <= 1'b0;
            w_af_q   <= 1'b0;
            w_free_q <= DEPTH_V;
            w_ovf_q  <= 1'b0;
        end else begin
            w_bin_q  <= w_bin_d;
            w_ptr_q  <= w_ptr_d;
            w_full_q <= w_full_d;
            w_af_q   <= w_af_d;
            w_free_q <= w_free_d;
            w_ovf_q  <= w_ovf_d;
        end
    end

    assign w_ptr         = w_ptr_q;
    assign w_addr        = w_bin_q[A-1:0];
    assign w_full        = w_full_q;
    assign w_almost_full = w_af_q;
    assign w_free        = w_free_q;
    assign w_overflow    = w_ovf_q;

endmodule
